// File: rtl/serial_proto_pkg.sv
// rtl/serial_proto_pkg.sv - framing constants, FSM state type and byte encoder shared with the decoder side
package serial_proto_pkg;

    localparam logic [7:0] FRAME_START = 8'hFF;
    localparam logic [7:0] FRAME_STOP  = 8'hBF;
    localparam int         FIELD_W     = 6;
    localparam int         MAG_W       = 20;
    localparam int         SIGN_BIT    = 3;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FETCH,
        SEND,
        CSUM,
        TRL,
        FIN
    } enc_state_t;

    // Data bytes carry at most 6 payload bits, so they can never alias the framing bytes
    function automatic logic [7:0] encode_byte(input logic [MAG_W-1:0] mag,
                                               input logic             sign,
                                               input logic [1:0]       idx);
        logic [7:0] b;
        b = 8'h00;
        case (idx)
            2'd0: b = {2'b00, mag[0*FIELD_W +: FIELD_W]};
            2'd1: b = {2'b00, mag[1*FIELD_W +: FIELD_W]};
            2'd2: b = {2'b00, mag[2*FIELD_W +: FIELD_W]};
            default: begin
                b[SIGN_BIT] = sign;
                b[1:0]      = mag[MAG_W-1 -: 2];
            end
        endcase
        return b;
    endfunction

endpackage

// File: rtl/byte_pacer.sv
// rtl/byte_pacer.sv - byte-slot down-counter that ticks one cycle before the next strobe is due
module byte_pacer #(
    parameter int BYTE_PERIOD = 2200
) (
    input  logic clk25,
    input  logic reset,
    input  logic load,
    output logic tick
);

    localparam int CW = $clog2(BYTE_PERIOD);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= CW'(BYTE_PERIOD - 1);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Ticking at 1 lets the registered strobe land exactly BYTE_PERIOD cycles after the last one
    assign tick = (cnt == CW'(1));

endmodule

// File: rtl/serial_result_encoder.sv
// rtl/serial_result_encoder.sv - frames signed result words into paced 6-bit UART bytes; SERIAL_ENC_CHECKSUM_EN adds a checksum byte
module serial_result_encoder
    import serial_proto_pkg::*;
#(
    parameter int BYTE_PERIOD = 2200,
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 21
) (
    input  logic                     clk25,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        num_words,
    output logic [ADDR_W-1:0]        rd_addr,
    input  logic signed [DATA_W-1:0] rd_data,
    output logic signed [DATA_W-1:0] data_tx,
    output logic                     enable_tx,
    output logic                     busy,
    output logic                     done
);

    enc_state_t        state, state_nxt;
    logic              tick;
    logic [ADDR_W-1:0] n_words;
    logic [MAG_W-1:0]  mag_q;
    logic              sign_q;
    logic [1:0]        byte_idx;
    logic              fetch_wait;
    logic              last_word;
    logic [DATA_W-1:0] abs_val;
    logic [MAG_W-1:0]  mag_in;

    logic       fire, accept, capture, advance_addr, finish;
    logic [7:0] tx_byte;

`ifdef SERIAL_ENC_CHECKSUM_EN
    logic [FIELD_W-1:0] sum_q;
`endif

    byte_pacer #(.BYTE_PERIOD(BYTE_PERIOD)) u_pacer (
        .clk25 (clk25),
        .reset (reset),
        .load  (enable_tx),
        .tick  (tick)
    );

    // -2^20 has no positive twin in the word width, so it saturates to the largest magnitude
    assign abs_val   = rd_data[DATA_W-1] ? $unsigned(-rd_data) : $unsigned(rd_data);
    assign mag_in    = (|abs_val[DATA_W-1:MAG_W]) ? '1 : abs_val[MAG_W-1:0];
    assign last_word = (rd_addr == n_words - ADDR_W'(1));

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = HDR;
            HDR:   state_nxt = (n_words == '0) ? TRL : FETCH;
            FETCH: if (!fetch_wait) state_nxt = SEND;
            SEND: begin
                if (tick && byte_idx == 2'd3) begin
`ifdef SERIAL_ENC_CHECKSUM_EN
                    state_nxt = last_word ? CSUM : FETCH;
`else
                    state_nxt = last_word ? TRL : FETCH;
`endif
                end
            end
`ifdef SERIAL_ENC_CHECKSUM_EN
            CSUM:  if (tick) state_nxt = TRL;
`endif
            TRL:   if (tick) state_nxt = FIN;
            FIN:   if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        fire         = 1'b0;
        accept       = 1'b0;
        capture      = 1'b0;
        advance_addr = 1'b0;
        finish       = 1'b0;
        tx_byte      = 8'h00;
        case (state)
            IDLE: begin
                if (start) begin
                    fire    = 1'b1;
                    accept  = 1'b1;
                    tx_byte = FRAME_START;
                end
            end
            FETCH: capture = !fetch_wait;
            SEND: begin
                if (tick) begin
                    fire         = 1'b1;
                    tx_byte      = encode_byte(mag_q, sign_q, byte_idx);
                    advance_addr = (byte_idx == 2'd3) && !last_word;
                end
            end
`ifdef SERIAL_ENC_CHECKSUM_EN
            CSUM: begin
                if (tick) begin
                    fire    = 1'b1;
                    tx_byte = {2'b00, sum_q};
                end
            end
`endif
            TRL: begin
                if (tick) begin
                    fire    = 1'b1;
                    tx_byte = FRAME_STOP;
                end
            end
            FIN: finish = tick;
            default: ;
        endcase
    end

    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            rd_addr    <= '0;
            data_tx    <= '0;
            enable_tx  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            n_words    <= '0;
            mag_q      <= '0;
            sign_q     <= 1'b0;
            byte_idx   <= 2'd0;
            fetch_wait <= 1'b0;
        end else begin
            enable_tx <= fire;
            done      <= finish;
            if (fire) begin
                data_tx <= {{(DATA_W-8){1'b0}}, tx_byte};
            end
            if (accept) begin
                busy       <= 1'b1;
                n_words    <= num_words;
                rd_addr    <= '0;
                byte_idx   <= 2'd0;
                fetch_wait <= 1'b0;
            end
            if (finish) begin
                busy <= 1'b0;
            end
            if (capture) begin
                mag_q    <= mag_in;
                sign_q   <= rd_data[DATA_W-1];
                byte_idx <= 2'd0;
            end
            if (fire && state == SEND) begin
                byte_idx <= byte_idx + 2'd1;
            end
            // The new address needs a settle cycle before the memory returns its word
            if (advance_addr) begin
                rd_addr    <= rd_addr + ADDR_W'(1);
                fetch_wait <= 1'b1;
            end else if (state == FETCH && fetch_wait) begin
                fetch_wait <= 1'b0;
            end
        end
    end

`ifdef SERIAL_ENC_CHECKSUM_EN
    always_ff @(posedge clk25 or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else if (accept) begin
            sum_q <= '0;
        end else if (fire && state == SEND) begin
            sum_q <= sum_q + tx_byte[FIELD_W-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_serial_result_encoder.sv
// tb/tb_serial_result_encoder.sv - scoreboard bench for serial_result_encoder; follows SERIAL_ENC_CHECKSUM_EN when defined
module tb_serial_result_encoder;

    localparam int BP     = 40;
    localparam int ADDR_W = 24;
    localparam int DATA_W = 21;

    logic                     clk25 = 1'b0;
    logic                     reset;
    logic                     start;
    logic [ADDR_W-1:0]        num_words;
    logic [ADDR_W-1:0]        rd_addr;
    logic signed [DATA_W-1:0] rd_data = '0;
    logic signed [DATA_W-1:0] data_tx;
    logic                     enable_tx;
    logic                     busy;
    logic                     done;

    logic signed [DATA_W-1:0] mem [8];
    logic [7:0]               exp_q[$];
    logic [7:0]               dq[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int start_cyc, last_tx, max_addr, exp_max, frame_pulses;
    bit first_pending = 0;
    bit frame_done    = 0;

    serial_result_encoder #(.BYTE_PERIOD(BP), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk25     (clk25),
        .reset     (reset),
        .start     (start),
        .num_words (num_words),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .data_tx   (data_tx),
        .enable_tx (enable_tx),
        .busy      (busy),
        .done      (done)
    );

    always #20 clk25 = ~clk25;

    always @(posedge clk25) begin
        cyc++;
        rd_data <= mem[rd_addr[2:0]];
    end

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    always @(negedge clk25) begin
        logic [7:0] e;
        if (busy && int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
        if (enable_tx) begin
            frame_pulses++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse got=%0h want=none", data_tx);
            end else begin
                e = exp_q.pop_front();
                check("tx_byte", int'(data_tx), int'(e));
            end
            if (first_pending) check("first_latency", cyc - start_cyc, 1);
            else               check("byte_gap", cyc - last_tx, BP);
            first_pending = 0;
            last_tx = cyc;
        end
        if (done) begin
            check("done_delay", cyc - last_tx, BP);
            check("leftover_bytes", exp_q.size(), 0);
            check("busy_at_done", int'(busy), 0);
            check("max_rd_addr", max_addr, exp_max);
            frame_done = 1;
        end
    end

    task automatic push_expected();
        logic [5:0] s;
        s = '0;
        exp_q.push_back(8'hFF);
        foreach (dq[i]) begin
            exp_q.push_back(dq[i]);
            s = s + dq[i][5:0];
        end
`ifdef SERIAL_ENC_CHECKSUM_EN
        exp_q.push_back({2'b00, s});
`endif
        exp_q.push_back(8'hBF);
    endtask

    task automatic start_frame(input int n, input int mx);
        @(negedge clk25);
        num_words     = ADDR_W'(n);
        start         = 1'b1;
        start_cyc     = cyc;
        first_pending = 1;
        max_addr      = 0;
        exp_max       = mx;
        frame_pulses  = 0;
        frame_done    = 0;
        @(negedge clk25);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (!frame_done && k < limit) begin
            @(negedge clk25);
            k++;
        end
        if (!frame_done) begin
            total++;
            bad++;
            $display("FAIL done_timeout got=0 want=1");
        end
        repeat (3) @(negedge clk25);
    endtask

    task automatic run_one(input logic signed [DATA_W-1:0] w);
        mem[0] = w;
        push_expected();
        start_frame(1, 0);
        wait_done(8 * BP);
    endtask

    task automatic load_three();
        mem[0] = 21'sd1;
        mem[1] = -21'sd64;
        mem[2] = 21'sh0FFFFF;
        dq = '{8'h01, 8'h00, 8'h00, 8'h00,
               8'h00, 8'h01, 8'h00, 8'h08,
               8'h3F, 8'h3F, 8'h3F, 8'h03};
    endtask

    initial begin
        int k;
        reset     = 1'b0;
        start     = 1'b0;
        num_words = '0;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        repeat (3) @(negedge clk25);
        check("reset_rd_addr", int'(rd_addr), 0);
        check("reset_data_tx", int'(data_tx), 0);
        check("reset_enable_tx", int'(enable_tx), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk25);

        dq = '{8'h05, 8'h00, 8'h00, 8'h08};
        run_one(-21'sd5);
        dq = '{8'h05, 8'h0D, 8'h12, 8'h00};
        run_one(21'sh012345);
        dq = '{8'h3F, 8'h3F, 8'h3F, 8'h0B};
        run_one(21'sh100000);
        dq = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_one(21'sd0);

        dq = {};
        push_expected();
        start_frame(0, 0);
        wait_done(4 * BP);

        load_three();
        push_expected();
        start_frame(3, 2);
        repeat (3 * BP) @(negedge clk25);
        num_words = ADDR_W'(1);
        start     = 1'b1;
        @(negedge clk25);
        start = 1'b0;
        wait_done(20 * BP);

        load_three();
        push_expected();
        start_frame(3, 2);
        k = 0;
        while (frame_pulses < 8 && k < 12 * BP) begin
            @(negedge clk25);
            k++;
        end
        check("reached_word1_byte2", frame_pulses, 8);
        repeat (BP / 2) @(negedge clk25);
        reset = 1'b0;
        exp_q.delete();
        first_pending = 0;
        #1;
        check("abort_enable_tx", int'(enable_tx), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_rd_addr", int'(rd_addr), 0);
        check("abort_data_tx", int'(data_tx), 0);
        repeat (3) @(negedge clk25);
        reset = 1'b1;
        repeat (3 * BP) @(negedge clk25);
        check("idle_after_abort_busy", int'(busy), 0);
        check("no_done_after_abort", int'(frame_done), 0);

        push_expected();
        start_frame(3, 2);
        wait_done(20 * BP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
